branch_predictor: RTL and testbench

Commit-trained tournament branch predictor. It sits beside the instruction unit and gives a taken/not-taken prediction for a fetch address in the same cycle. It also returns the two table indices used, which travel with the branch through the reorder buffer. The reorder buffer sends each committed branch back (ready, result, correct, indices), and that commit-time update trains the tables.

---
 rtl/branch_predictor.sv | 127 ++++++++++++
 tb/tb_branch_predictor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Commit-trained tournament branch predictor. A fetch PC is looked up
//   combinationally, giving a taken/not-taken prediction plus the two table
//   indices used. Those indices travel with the branch and come back at commit,
//   where they select the entries to train.
//
//   Build option: define BP_TOURNAMENT_EN for the full tournament (global
//   counters, selector table and committed global history). Without it only
//   the local counter table is built, pred_g_ind is tied to zero and
//   upd_g_ind is ignored.
//
// Ports
//   clk_in       clock, rising edge
//   rst_in       asynchronous active-high reset
//   rdy_in       low = pause, no state changes
//   query_addr   fetch PC to predict
//   pred_out     prediction (0/1, zero-extended), combinational
//   pred_g_ind   global table index used by the lookup
//   pred_l_ind   local/selector table index used by the lookup
//   upd_valid    a committed branch is presented this cycle
//   upd_res      actual outcome, bit 0 only (1 = taken)
//   upd_correct  ROB correctness flag, not used for training
//   upd_g_ind    global index returned with the branch
//   upd_l_ind    local index returned with the branch
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int PRED_TABLE_BIT = 6
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic [31:0]               query_addr,
  output logic [31:0]               pred_out,
  output logic [PRED_TABLE_BIT-1:0] pred_g_ind,
  output logic [PRED_TABLE_BIT-1:0] pred_l_ind,
  input  logic                      upd_valid,
  input  logic [31:0]               upd_res,
  input  logic                      upd_correct,
  input  logic [PRED_TABLE_BIT-1:0] upd_g_ind,
  input  logic [PRED_TABLE_BIT-1:0] upd_l_ind
);

  localparam int N = 1 << PRED_TABLE_BIT;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  logic       upd_en;
  logic       upd_taken;
  logic       lp;
  logic [1:0] l_cnt_d;
  logic [1:0] l_cnt_q [N];

  assign upd_en    = rdy_in & upd_valid;
  assign upd_taken = upd_res[0];

  // Halfword granularity so compressed instructions get their own entries.
  assign pred_l_ind = query_addr[PRED_TABLE_BIT:1];
  assign lp         = l_cnt_q[pred_l_ind][1];
  assign l_cnt_d    = sat_step(l_cnt_q[upd_l_ind], upd_taken);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < N; i++) l_cnt_q[i] <= 2'b01;
    end else if (upd_en) begin
      l_cnt_q[upd_l_ind] <= l_cnt_d;
    end
  end

`ifdef BP_TOURNAMENT_EN
  logic                      gp;
  logic                      g_ok;
  logic                      l_ok;
  logic [1:0]                g_cnt_d;
  logic [1:0]                sel_d;
  logic [PRED_TABLE_BIT-1:0] ghr_d;
  logic [1:0]                g_cnt_q [N];
  logic [1:0]                sel_q   [N];
  logic [PRED_TABLE_BIT-1:0] ghr_q;

  assign pred_g_ind = pred_l_ind ^ ghr_q;
  assign gp         = g_cnt_q[pred_g_ind][1];
  assign pred_out   = {31'b0, sel_q[pred_l_ind][1] ? gp : lp};

  // Selector is judged on the component predictions as they stood before
  // this update trains them.
  assign l_ok    = (l_cnt_q[upd_l_ind][1] == upd_taken);
  assign g_ok    = (g_cnt_q[upd_g_ind][1] == upd_taken);
  assign g_cnt_d = sat_step(g_cnt_q[upd_g_ind], upd_taken);
  assign ghr_d   = {ghr_q[PRED_TABLE_BIT-2:0], upd_taken};

  always_comb begin
    sel_d = sel_q[upd_l_ind];
    if (g_ok && !l_ok)      sel_d = sat_step(sel_q[upd_l_ind], 1'b1);
    else if (l_ok && !g_ok) sel_d = sat_step(sel_q[upd_l_ind], 1'b0);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < N; i++) begin
        g_cnt_q[i] <= 2'b01;
        sel_q[i]   <= 2'b01;
      end
      ghr_q <= '0;
    end else if (upd_en) begin
      g_cnt_q[upd_g_ind] <= g_cnt_d;
      sel_q[upd_l_ind]   <= sel_d;
      ghr_q              <= ghr_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{upd_correct, upd_res[31:1],
                         query_addr[31:PRED_TABLE_BIT+1], query_addr[0]};
`else
  assign pred_g_ind = '0;
  assign pred_out   = {31'b0, lp};

  logic unused_bits;
  assign unused_bits = ^{upd_correct, upd_res[31:1], upd_g_ind,
                         query_addr[31:PRED_TABLE_BIT+1], query_addr[0]};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//   Directed bench for branch_predictor with PRED_TABLE_BIT = 6. Expected
//   values are hand-derived; where the tournament option changes a result
//   both values are listed and TOURN picks the one matching this build.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

`ifdef BP_TOURNAMENT_EN
  localparam bit TOURN = 1'b1;
`else
  localparam bit TOURN = 1'b0;
`endif

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] query_addr;
  logic [31:0] pred_out;
  logic [5:0]  pred_g_ind;
  logic [5:0]  pred_l_ind;
  logic        upd_valid;
  logic [31:0] upd_res;
  logic        upd_correct;
  logic [5:0]  upd_g_ind;
  logic [5:0]  upd_l_ind;

  int n_vec;
  int n_err;

  branch_predictor #(.PRED_TABLE_BIT(6)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .query_addr  (query_addr),
    .pred_out    (pred_out),
    .pred_g_ind  (pred_g_ind),
    .pred_l_ind  (pred_l_ind),
    .upd_valid   (upd_valid),
    .upd_res     (upd_res),
    .upd_correct (upd_correct),
    .upd_g_ind   (upd_g_ind),
    .upd_l_ind   (upd_l_ind)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One committed branch; drives at a falling edge, returns at the next one.
  task automatic upd(input logic [5:0] l, input logic [5:0] g, input logic t);
    @(negedge clk_in);
    upd_l_ind = l;
    upd_g_ind = g;
    upd_res   = {31'b0, t};
    upd_valid = 1'b1;
    @(negedge clk_in);
    upd_valid = 1'b0;
  endtask

  task automatic query(input logic [31:0] a);
    query_addr = a;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst_in      = 1'b1;
    rdy_in      = 1'b1;
    query_addr  = 32'h0;
    upd_valid   = 1'b0;
    upd_res     = 32'h0;
    upd_correct = 1'b0;
    upd_g_ind   = 6'd0;
    upd_l_ind   = 6'd0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;

    // Reset state
    query(32'h104);
    check("rst_pred",  pred_out,          32'd0);
    check("rst_l_ind", {26'b0, pred_l_ind}, 32'd2);
    check("rst_g_ind", {26'b0, pred_g_ind}, TOURN ? 32'd2 : 32'd0);

    // Same-cycle lookup sees pre-update value
    @(negedge clk_in);
    upd_l_ind = 6'd2; upd_g_ind = 6'd2; upd_res = 32'd1; upd_valid = 1'b1;
    #1;
    check("same_cycle_pred", pred_out, 32'd0);
    @(negedge clk_in);
    upd_valid = 1'b0;
    query(32'h104);
    check("upd1_pred",  pred_out,            32'd1);
    check("upd1_g_ind", {26'b0, pred_g_ind}, TOURN ? 32'd3 : 32'd0);

    // Saturation high then low on l_cnt[5]
    do_reset();
    repeat (6) upd(6'd5, 6'd5, 1'b1);
    upd(6'd5, 6'd5, 1'b0);
    query(32'h10A);
    check("sat_hi_pred",  pred_out,            32'd1);
    check("sat_hi_l_ind", {26'b0, pred_l_ind}, 32'd5);
    check("sat_hi_g_ind", {26'b0, pred_g_ind}, TOURN ? 32'h3B : 32'd0);
    repeat (3) upd(6'd5, 6'd5, 1'b0);
    upd(6'd5, 6'd5, 1'b1);
    query(32'h10A);
    check("sat_lo_pred1", pred_out, 32'd0);
    upd(6'd5, 6'd5, 1'b1);
    query(32'h10A);
    check("sat_lo_pred2", pred_out, 32'd1);

    // Selector training
    do_reset();
    upd(6'd9, 6'd7, 1'b1);
    upd(6'd9, 6'd7, 1'b1);   // g_cnt[7]=3
    upd(6'd4, 6'd8, 1'b0);   // l_cnt[4]=0
    upd(6'd4, 6'd7, 1'b1);   // sel[4]=2
    upd(6'd4, 6'd7, 1'b1);   // sel[4]=3, l_cnt[4]=2, ghr=0x1B
    query(32'h8);
    check("sel_up_pred",  pred_out,            TOURN ? 32'd0 : 32'd1);
    check("sel_up_g_ind", {26'b0, pred_g_ind}, TOURN ? 32'h1F : 32'd0);
    upd(6'd4, 6'd8, 1'b1);   // only local correct: sel[4]=2
    upd(6'd4, 6'd8, 1'b1);   // sel[4]=1, l_cnt[4]=3, ghr=0x2F
    query(32'h8);
    check("sel_dn_pred",  pred_out,            32'd1);
    check("sel_dn_g_ind", {26'b0, pred_g_ind}, TOURN ? 32'h2B : 32'd0);

    // Pause: updates ignored for three cycles
    @(negedge clk_in);
    rdy_in = 1'b0;
    upd_l_ind = 6'd4; upd_g_ind = 6'd4; upd_res = 32'd0; upd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check("pause_pred", pred_out, 32'd1);
    end
    upd_valid = 1'b0;
    rdy_in = 1'b1;
    query(32'h8);
    check("post_pause_pred",  pred_out,            32'd1);
    check("post_pause_g_ind", {26'b0, pred_g_ind}, TOURN ? 32'h2B : 32'd0);

    // Asynchronous reset between edges
    @(negedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    check("async_rst_pred",  pred_out,            32'd0);
    check("async_rst_g_ind", {26'b0, pred_g_ind}, TOURN ? 32'd4 : 32'd0);
    upd_l_ind = 6'd4; upd_g_ind = 6'd4; upd_res = 32'd1; upd_valid = 1'b1;
    repeat (2) @(negedge clk_in);
    upd_valid = 1'b0;
    rst_in = 1'b0;
    query(32'h8);
    check("rst_drop_pred", pred_out, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
